// File: rtl/simd_flag_gen.sv
// simd_flag_gen: two-stage SIMD status-flag generator feeding statusreg DIN/CE.
// Optional sticky-overflow mode is enabled by defining FLAG_STICKY_EN.
module simd_flag_gen #(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          RES_VALID,
    input  logic [DW-1:0] RES_DATA,
    input  logic [1:0]    LANE_MODE,
    input  logic [3:0]    LANE_CARRY,
    input  logic [3:0]    LANE_OVF,
    input  logic          HOLD,
    input  logic          CLR_STICKY,
    output logic [4:0]    FLAGS,
    output logic          FLAGS_CE,
    output logic          BUSY
);

    localparam logic [1:0] MODE_1X32 = 2'b00;
    localparam logic [1:0] MODE_2X16 = 2'b01;
    localparam logic [1:0] MODE_4X8  = 2'b10;

    // Stage-1 state
    logic          v1_reg;
    logic [DW-1:0] data_reg;
    logic [1:0]    mode_reg;
    logic [3:0]    carry_reg;
    logic [3:0]    ovf_reg;

    // Stage-2 state
    logic [4:0]    flags_reg;
    logic          flags_ce_reg;

    // Capture-side lane decode
    logic [1:0]    mode_next;
    logic [3:0]    lane_mask_next;

    // Issue-side combinational flag terms
    logic [3:0]    byte_zero;
    logic [1:0]    half_zero;
    logic          issue;
    logic          z_next;
    logic          n_next;
    logic          c_next;
    logic          v_comp;
    logic          v_next;
    logic          p_next;
    logic [4:0]    flags_next;

    // Reserved mode 11 collapses to 1x32 at capture so stage 2 sees only 3 modes.
    always_comb begin
        mode_next      = (LANE_MODE == 2'b11) ? MODE_1X32 : LANE_MODE;
        lane_mask_next = 4'b0001;
        case (mode_next)
            MODE_2X16: lane_mask_next = 4'b0011;
            MODE_4X8:  lane_mask_next = 4'b1111;
            default:   lane_mask_next = 4'b0001;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1_reg    <= 1'b0;
            data_reg  <= '0;
            mode_reg  <= MODE_1X32;
            carry_reg <= '0;
            ovf_reg   <= '0;
        end else if (!HOLD) begin
            v1_reg <= RES_VALID;
            if (RES_VALID) begin
                data_reg  <= RES_DATA;
                mode_reg  <= mode_next;
                carry_reg <= LANE_CARRY & lane_mask_next;
                ovf_reg   <= LANE_OVF & lane_mask_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_zero
            assign byte_zero[gi] = (data_reg[gi*8 +: 8] == 8'h00);
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_zero
            assign half_zero[gi] = byte_zero[2*gi] & byte_zero[2*gi+1];
        end
    endgenerate

    assign issue = v1_reg & ~HOLD;

    always_comb begin
        z_next = &byte_zero;
        c_next = |carry_reg;
        v_comp = |ovf_reg;
        n_next = data_reg[31];
        p_next = 1'b0;
        case (mode_reg)
            MODE_2X16: begin
                n_next = data_reg[31] | data_reg[15];
                p_next = (|half_zero) & ~z_next;
            end
            MODE_4X8: begin
                n_next = data_reg[31] | data_reg[23] | data_reg[15] | data_reg[7];
                p_next = (|byte_zero) & ~z_next;
            end
            default: begin
                n_next = data_reg[31];
                p_next = 1'b0;
            end
        endcase
    end

`ifdef FLAG_STICKY_EN
    logic sticky_reg;
    logic sticky_eff;

    // A clear in the issue cycle wipes history before the new overflow is ORed in.
    assign sticky_eff = CLR_STICKY ? 1'b0 : sticky_reg;
    assign v_next     = sticky_eff | v_comp;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sticky_reg <= 1'b0;
        end else if (!HOLD) begin
            if (issue) begin
                sticky_reg <= sticky_eff | v_comp;
            end else if (CLR_STICKY) begin
                sticky_reg <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = CLR_STICKY;
    assign v_next            = v_comp;
`endif

    assign flags_next = {p_next, v_next, c_next, n_next, z_next};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_reg    <= 5'b0;
            flags_ce_reg <= 1'b0;
        end else begin
            flags_ce_reg <= issue;
            if (issue) begin
                flags_reg <= flags_next;
            end
        end
    end

    assign FLAGS    = flags_reg;
    assign FLAGS_CE = flags_ce_reg;
    assign BUSY     = v1_reg;

endmodule

// File: tb/tb_simd_flag_gen.sv
// Directed-vector bench for simd_flag_gen; expectations are hand-computed flag words.
module tb_simd_flag_gen;

`ifdef FLAG_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RES_VALID;
    logic [31:0] RES_DATA;
    logic [1:0]  LANE_MODE;
    logic [3:0]  LANE_CARRY;
    logic [3:0]  LANE_OVF;
    logic        HOLD;
    logic        CLR_STICKY;
    logic [4:0]  FLAGS;
    logic        FLAGS_CE;
    logic        BUSY;

    int n_vec = 0;
    int n_bad = 0;

    simd_flag_gen #(.DW(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RES_VALID  (RES_VALID),
        .RES_DATA   (RES_DATA),
        .LANE_MODE  (LANE_MODE),
        .LANE_CARRY (LANE_CARRY),
        .LANE_OVF   (LANE_OVF),
        .HOLD       (HOLD),
        .CLR_STICKY (CLR_STICKY),
        .FLAGS      (FLAGS),
        .FLAGS_CE   (FLAGS_CE),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one result for a single edge, then drop RES_VALID.
    task automatic send(input logic [1:0] mode, input logic [31:0] data,
                        input logic [3:0] carry, input logic [3:0] ovf);
        RES_VALID  = 1'b1;
        LANE_MODE  = mode;
        RES_DATA   = data;
        LANE_CARRY = carry;
        LANE_OVF   = ovf;
        step();
        RES_VALID  = 1'b0;
    endtask

    // Single result through the pipe: strobe on issue edge, then quiet with FLAGS held.
    task automatic one_result(input string tag, input logic [1:0] mode, input logic [31:0] data,
                              input logic [3:0] carry, input logic [3:0] ovf, input logic [4:0] exp);
        send(mode, data, carry, ovf);
        step();
        check_vec({tag, "_flags"}, 32'(FLAGS), 32'(exp));
        check_vec({tag, "_ce"}, 32'(FLAGS_CE), 32'd1);
        step();
        check_vec({tag, "_ce_off"}, 32'(FLAGS_CE), 32'd0);
    endtask

    initial begin
        RESET = 1'b1; RES_VALID = 1'b0; RES_DATA = '0; LANE_MODE = 2'b00;
        LANE_CARRY = '0; LANE_OVF = '0; HOLD = 1'b0; CLR_STICKY = 1'b0;
        step();
        step();
        check_vec("rst_flags", 32'(FLAGS), 32'd0);
        check_vec("rst_ce", 32'(FLAGS_CE), 32'd0);
        check_vec("rst_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        step();

        // Reset mid-flight discards the captured entry
        send(2'b00, 32'h0, 4'h0, 4'h0);
        check_vec("mid_busy", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check_vec("mid_ce1", 32'(FLAGS_CE), 32'd0);
        check_vec("mid_flags", 32'(FLAGS), 32'd0);
        check_vec("mid_busy0", 32'(BUSY), 32'd0);
        step();
        check_vec("mid_ce2", 32'(FLAGS_CE), 32'd0);
        step();
        check_vec("mid_ce3", 32'(FLAGS_CE), 32'd0);

        one_result("x8_mix",  2'b10, 32'h0080007F, 4'b0010, 4'b0000, 5'b10110);
        one_result("x32_zero", 2'b00, 32'h00000000, 4'b1110, 4'b0000, 5'b00001);
        one_result("x16_neg", 2'b01, 32'h00008000, 4'b0000, 4'b0000, 5'b10010);
        one_result("rsv_mode", 2'b11, 32'h00008000, 4'b0000, 4'b0000, 5'b00000);
        one_result("x16_mask", 2'b01, 32'h12340000, 4'b1110, 4'b1100, 5'b10100);
        one_result("x8_allff", 2'b10, 32'hFFFFFFFF, 4'b1000, 4'b0000, 5'b00110);

        // Back-to-back: A, B, C on consecutive edges
        send(2'b10, 32'hFFFFFFFF, 4'b0000, 4'b0000);
        RES_VALID = 1'b1; LANE_MODE = 2'b00; RES_DATA = 32'h80000000;
        LANE_CARRY = 4'b0001; LANE_OVF = 4'b0000;
        step();
        check_vec("b2b_a_ce", 32'(FLAGS_CE), 32'd1);
        check_vec("b2b_a", 32'(FLAGS), 32'(5'b00010));
        LANE_MODE = 2'b01; RES_DATA = 32'h0; LANE_CARRY = 4'b0000;
        step();
        RES_VALID = 1'b0;
        check_vec("b2b_b_ce", 32'(FLAGS_CE), 32'd1);
        check_vec("b2b_b", 32'(FLAGS), 32'(5'b00110));
        step();
        check_vec("b2b_c_ce", 32'(FLAGS_CE), 32'd1);
        check_vec("b2b_c", 32'(FLAGS), 32'(5'b00001));
        step();
        check_vec("b2b_idle", 32'(FLAGS_CE), 32'd0);

        // HOLD for two cycles mid-stream: A pending, B held by producer
        send(2'b10, 32'hFFFFFFFF, 4'b0000, 4'b0000);
        RES_VALID = 1'b1; LANE_MODE = 2'b00; RES_DATA = 32'h80000000;
        LANE_CARRY = 4'b0001; LANE_OVF = 4'b0000; HOLD = 1'b1;
        step();
        check_vec("hold1_ce", 32'(FLAGS_CE), 32'd0);
        check_vec("hold1_flags", 32'(FLAGS), 32'(5'b00001));
        check_vec("hold1_busy", 32'(BUSY), 32'd1);
        step();
        check_vec("hold2_ce", 32'(FLAGS_CE), 32'd0);
        HOLD = 1'b0;
        step();
        RES_VALID = 1'b0;
        check_vec("hold_a_ce", 32'(FLAGS_CE), 32'd1);
        check_vec("hold_a", 32'(FLAGS), 32'(5'b00010));
        step();
        check_vec("hold_b_ce", 32'(FLAGS_CE), 32'd1);
        check_vec("hold_b", 32'(FLAGS), 32'(5'b00110));
        step();
        check_vec("hold_idle", 32'(FLAGS_CE), 32'd0);
        check_vec("hold_busy0", 32'(BUSY), 32'd0);

        // Overflow history
        one_result("ovf_set", 2'b01, 32'h00010001, 4'b0000, 4'b0001, 5'b01000);
        one_result("ovf_next", 2'b01, 32'h00010001, 4'b0000, 4'b0000,
                   STICKY ? 5'b01000 : 5'b00000);
        CLR_STICKY = 1'b1;
        step();
        CLR_STICKY = 1'b0;
        one_result("clr_clean", 2'b01, 32'h00010001, 4'b0000, 4'b0000, 5'b00000);

        // Clear coincident with an overflowing issue: V stays set, and so does S
        send(2'b01, 32'h00010001, 4'b0000, 4'b0001);
        CLR_STICKY = 1'b1;
        step();
        CLR_STICKY = 1'b0;
        check_vec("clr_ovf", 32'(FLAGS), 32'(5'b01000));
        check_vec("clr_ovf_ce", 32'(FLAGS_CE), 32'd1);
        one_result("s_kept", 2'b01, 32'h00010001, 4'b0000, 4'b0000,
                   STICKY ? 5'b01000 : 5'b00000);

        // Clear coincident with a clean issue: history wiped before OR-in
        send(2'b01, 32'h00010001, 4'b0000, 4'b0000);
        CLR_STICKY = 1'b1;
        step();
        CLR_STICKY = 1'b0;
        check_vec("clr_clean_issue", 32'(FLAGS), 32'(5'b00000));
        step();
        one_result("after_clr", 2'b01, 32'h00010001, 4'b0000, 4'b0000, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
